serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits (legal N >= 1).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on the rising clk edge.
REQ-005 SHALL have port a  input  N  operand A; captured only on an accepted start.
REQ-006 SHALL have port b  input  N  operand B; captured only on an accepted start.
REQ-007 SHALL have port c_in  input  1  carry-in; captured only on an accepted start.
REQ-008 SHALL have port ready  output  1  high when a start will be accepted.
REQ-009 SHALL have port done  output  1  high while sum, c_out and overflow hold a valid result.
REQ-010 SHALL have port sum  output  N  result a+b+c_in, modulo 2^N.
REQ-011 SHALL have port c_out  output  1  unsigned carry out of bit N-1.
REQ-012 SHALL have port overflow  output  1  two's-complement overflow: carry into bit N-1 XOR c_out.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 SHALL drive ready=1 in IDLE and DONE, and ready=0 in BUSY.
REQ-015 SHALL, on start=1 with ready=1, load a and b into shift registers, load c_in into the carry register, clear the bit counter, clear done, and enter BUSY.
REQ-016 SHALL, on each BUSY edge, add the operand LSBs and the carry using one full-adder bit slice, shift the operand registers right by one, shift the sum bit into the sum MSB, update the carry, and increment the counter.
REQ-017 SHALL leave BUSY after exactly N BUSY edges and enter DONE; done=1 is visible N cycles after the edge that accepted start.
REQ-018 SHALL hold sum, c_out, overflow and done stable in DONE until the next accepted start or reset.
REQ-019 SHALL capture the carry into bit N-1 on the final BUSY edge for the overflow computation.
REQ-020 SHALL ignore start while BUSY (no restart, no operand recapture).
REQ-021 SHALL accept start in DONE as a new operation (back-to-back), deasserting done on that edge.
REQ-022 SHALL support N=1: one BUSY cycle; overflow = c_in XOR c_out.
REQ-023 SHALL size the counter as $clog2(N+1) bits with no wrap before reaching N.
REQ-024 SHALL NOT let changes on a, b or c_in after capture affect the result.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-BUSY, immediately enter IDLE with sum=0, c_out=0, overflow=0, done=0, counter=0, carry=0, ready=1.
REQ-026 SHALL discard an in-progress operation on reset; no result is produced for it.

Structure
REQ-027 SHALL take the FSM state enum (IDLE/BUSY/DONE) from shared package adder_pkg.
REQ-028 SHALL instantiate exactly one existing full_adder sub-module as the bit-slice datapath.
REQ-029 SHALL contain no combinational path from start, a, b or c_in to any output.

Verification
REQ-030 N=4, a=0111, b=0001, c_in=0 -> after 4 cycles done=1, sum=1000, c_out=0, overflow=1.
REQ-031 N=4, a=1111, b=0001, c_in=0 -> sum=0000, c_out=1, overflow=0; a=0000, b=0000, c_in=1 -> sum=0001.
REQ-032 N=4, start with a=0011, b=0011; start again at cycle 2 with a=1111 -> second start ignored, sum=0110.
REQ-033 N=4, rst pulsed at cycle 2 of BUSY -> all outputs 0 and ready=1 immediately; new start 0010+0010 -> sum=0100.
REQ-034 N=4, start held high continuously -> back-to-back results, done pulses one cycle every 5 cycles.
REQ-035 N=1, all 8 combinations of a, b, c_in -> {c_out, sum} matches the full-adder truth table after 1 cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types for the serial adder.
package adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one bit per clock through a single full-adder slice.
module serial_adder
    import adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    localparam int CW = $clog2(N + 1);
    state_t        state;
    logic [N-1:0]  a_sh, b_sh, sum_r;
    logic [CW-1:0] cnt;
    logic          carry, c_out_r, ovf_r, s_bit, c_bit, accept, last;
    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c_in (carry),
        .sum  (s_bit),
        .c_out(c_bit)
    );
    assign ready    = state != BUSY;
    assign done     = state == DONE;
    assign accept   = start && ready;
    assign last     = cnt == CW'(N - 1);
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = ovf_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_r   <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            state   <= BUSY;
            a_sh    <= a;
            b_sh    <= b;
            carry   <= c_in;
            cnt     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == BUSY) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            sum_r <= N'({s_bit, sum_r} >> 1);
            carry <= c_bit;
            cnt   <= cnt + 1'b1;
            // carry still holds the carry into the MSB on the final slice
            if (last) begin
                state   <= DONE;
                c_out_r <= c_bit;
                ovf_r   <= carry ^ c_bit;
            end
        end
    end
endmodule
